// File: rtl/uart_rx_gen2_if.sv
// Signal bundle between a UART line/host side and uart_rx_gen2.
// master: the side driving the serial line, frame config and FIFO pops.
// slave:  the receiver itself.
interface uart_rx_gen2_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  RD_EN;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  Parity_Error;
    logic                  Stop_Error;
    logic                  Break_Det;
    logic                  Overrun;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, STOP2, Prescale, RD_EN,
        input  P_DATA, Data_valid, Parity_Error, Stop_Error, Break_Det, Overrun
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, STOP2, Prescale, RD_EN,
        output P_DATA, Data_valid, Parity_Error, Stop_Error, Break_Det, Overrun
    );
endinterface

// File: rtl/uart_rx_gen2.sv
// Oversampling UART receiver with 3-sample majority voting, optional parity,
// one or two stop bits and break detection.
// Build option UART_RX_FIFO_EN: adds a 4-entry receive FIFO with sticky Overrun.
// Without it Data_valid is a one-cycle pulse and P_DATA holds the last good word.
module uart_rx_gen2 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_gen2_if.slave rx_if
);

    localparam int unsigned BitCntW = 4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]            smp_q, smp_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  stop2_q, stop2_d;
    logic [PRESCALE_W-1:0] ps_q, ps_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop_err_q, stop_err_d;

    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  brk_q, brk_d;

    logic                  rx;
    logic [PRESCALE_W-1:0] half;
    logic                  at_s0, at_s1, at_dec, edge_last;
    logic [PRESCALE_W-1:0] edge_nxt;
    logic                  maj;
    logic                  frame_done, frame_ok, perr_ev, serr_ev, brk_ev;

    assign rx        = rx_if.RX_IN;
    assign half      = ps_q >> 1;
    assign at_s0     = (edge_cnt_q == (half - PRESCALE_W'(1)));
    assign at_s1     = (edge_cnt_q == half);
    assign at_dec    = (edge_cnt_q == (half + PRESCALE_W'(1)));
    assign edge_last = (edge_cnt_q == (ps_q - PRESCALE_W'(1)));
    assign edge_nxt  = edge_last ? '0 : edge_cnt_q + PRESCALE_W'(1);
    // Third sample is the live line value at the decision edge.
    assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx) | (smp_q[1] & rx);

    // Frame FSM: next state, counters, shift register and per-frame events.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        smp_d      = smp_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        ps_d       = ps_q;
        par_bit_d  = par_bit_q;
        stop_err_d = stop_err_q;
        frame_done = 1'b0;
        perr_ev    = 1'b0;
        serr_ev    = 1'b0;
        brk_ev     = 1'b0;

        if (state_q inside {StStart, StData, StParity, StStop}) begin
            if (at_s0) smp_d[0] = rx;
            if (at_s1) smp_d[1] = rx;
        end

        case (state_q)
            StIdle: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rx) begin
                    // This cycle is edge 0 of the start bit.
                    state_d    = StStart;
                    edge_cnt_d = PRESCALE_W'(1);
                    par_en_d   = rx_if.PAR_EN;
                    par_typ_d  = rx_if.PAR_TYP;
                    stop2_d    = rx_if.STOP2;
                    ps_d       = rx_if.Prescale;
                    par_bit_d  = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            StStart: begin
                edge_cnt_d = edge_nxt;
                if (at_dec && maj) begin
                    state_d    = StIdle;
                    edge_cnt_d = '0;
                end else if (edge_last) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                edge_cnt_d = edge_nxt;
                if (at_dec) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
                if (edge_last) begin
                    if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            StParity: begin
                edge_cnt_d = edge_nxt;
                if (at_dec) par_bit_d = maj;
                if (edge_last) begin
                    state_d   = StStop;
                    bit_cnt_d = '0;
                end
            end
            StStop: begin
                edge_cnt_d = edge_nxt;
                if (at_dec) begin
                    if (bit_cnt_q == '0) begin
                        if ((shift_q == '0) && !(par_en_q && par_bit_q) && !maj) begin
                            brk_ev     = 1'b1;
                            state_d    = StBrkWait;
                            edge_cnt_d = '0;
                        end else if (stop2_q) begin
                            stop_err_d = !maj;
                        end else begin
                            frame_done = 1'b1;
                            serr_ev    = !maj;
                        end
                    end else begin
                        frame_done = 1'b1;
                        serr_ev    = stop_err_q | !maj;
                    end
                    if (frame_done) begin
                        perr_ev    = par_en_q && (par_bit_q != ((^shift_q) ^ par_typ_q));
                        state_d    = StIdle;
                        edge_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end else if (edge_last) begin
                    bit_cnt_d = BitCntW'(1);
                end
            end
            StBrkWait: begin
                // Count consecutive high cycles; any low restarts the bit time.
                if (!rx) begin
                    edge_cnt_d = '0;
                end else if (edge_last) begin
                    state_d    = StIdle;
                    edge_cnt_d = '0;
                end else begin
                    edge_cnt_d = edge_nxt;
                end
            end
            default: begin
                state_d    = StIdle;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase

        frame_ok = frame_done && !perr_ev && !serr_ev;
        perr_d   = perr_ev;
        serr_d   = serr_ev;
        brk_d    = brk_ev;
    end

    // FSM state, datapath and error-pulse registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            smp_q      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            ps_q       <= '0;
            par_bit_q  <= 1'b0;
            stop_err_q <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            smp_q      <= smp_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            ps_q       <= ps_d;
            par_bit_q  <= par_bit_d;
            stop_err_q <= stop_err_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            brk_q      <= brk_d;
        end
    end

    assign rx_if.Parity_Error = perr_q;
    assign rx_if.Stop_Error   = serr_q;
    assign rx_if.Break_Det    = brk_q;

`ifdef UART_RX_FIFO_EN
    logic [DATA_WIDTH-1:0] mem_q [4];
    logic [DATA_WIDTH-1:0] mem_d [4];
    logic [1:0]            wr_q, wr_d;
    logic [1:0]            rd_q, rd_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  ovr_q, ovr_d;
    logic                  pop, push, full;

    // FIFO bookkeeping; a pop frees the slot for a same-cycle push when full.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        pop   = rx_if.RD_EN && (cnt_q != 3'd0);
        full  = (cnt_q == 3'd4);
        push  = frame_ok && (!full || pop);
        ovr_d = ovr_q | (frame_ok && full && !pop);
        if (push) begin
            mem_d[wr_q] = shift_q;
            wr_d        = wr_q + 2'd1;
        end
        if (pop) rd_d = rd_q + 2'd1;
        cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
    end

    // FIFO pointers, level and sticky overrun.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end

    // Storage needs no reset: it is only visible while the level is non-zero.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign rx_if.P_DATA     = (cnt_q != 3'd0) ? mem_q[rd_q] : '0;
    assign rx_if.Data_valid = (cnt_q != 3'd0);
    assign rx_if.Overrun    = ovr_q;
`else
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  unused_rd_en;

    assign unused_rd_en = rx_if.RD_EN;

    // Hold the last good word; error frames leave it untouched.
    always_comb begin
        p_data_d = frame_ok ? shift_q : p_data_q;
        dv_d     = frame_ok;
    end

    // Output word and valid pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            p_data_q <= '0;
            dv_q     <= 1'b0;
        end else begin
            p_data_q <= p_data_d;
            dv_q     <= dv_d;
        end
    end

    assign rx_if.P_DATA     = p_data_q;
    assign rx_if.Data_valid = dv_q;
    assign rx_if.Overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Self-checking bench for uart_rx_gen2. A frame-level model schedules the
// expected result of each frame at the cycle it must appear; a negedge
// process checks every output on every cycle after the first reset.
module tb_uart_rx_gen2;
    localparam int unsigned W  = 8;
    localparam int unsigned PW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_gen2_if #(.DATA_WIDTH(W), .PRESCALE_W(PW)) u_if ();

    uart_rx_gen2 #(.DATA_WIDTH(W), .PRESCALE_W(PW)) dut (
        .CLK   (clk),
        .RST   (rst),
        .rx_if (u_if)
    );

    typedef struct packed {
        logic         v;
        logic         pe;
        logic         se;
        logic         bk;
        logic [W-1:0] d;
    } ev_t;

    ev_t          ev_q [int];
    int           cyc = 0;
    bit           rst_s, rd_s, live;
    logic [W-1:0] m_pdata;
    logic [W-1:0] m_fifo [$];
    logic         m_ovr;
    int           n_tests = 0, n_fail = 0;
    int           last_dv_cyc, last_perr_cyc, last_serr_cyc, last_brk_cyc;
    int           n_dv_rise = 0, n_perr = 0, n_serr = 0, n_brk = 0;
    logic [W-1:0] last_dv_data;
    logic         dv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame and schedule its expected result.
    task automatic send_frame(input logic [W-1:0] d, input bit pe, input bit pt, input bit s2,
                              input int p, input bit pbit, input bit s0, input bit s1,
                              input bit mangle, output int c0);
        ev_t e;
        int  l;
        u_if.PAR_EN   = pe;
        u_if.PAR_TYP  = pt;
        u_if.STOP2    = s2;
        u_if.Prescale = PW'(p);
        u_if.RX_IN    = 1'b0;
        c0 = cyc;
        l  = 1 + int'(W) + (pe ? 1 : 0);
        e  = '0;
        if ((d == '0) && (!pe || !pbit) && !s0) begin
            e.bk = 1'b1;
        end else begin
            if (s2) l++;
            e.pe = pe && (pbit != ((^d) ^ pt));
            e.se = !s0 || (s2 && !s1);
            e.v  = !e.pe && !e.se;
            e.d  = d;
        end
        // Line sampled from cycle c0+1; result one cycle after the P/2+1 sample.
        ev_q[c0 + 2 + l * p + p / 2] = e;
        wait_cycles(p);
        if (mangle) begin
            u_if.PAR_EN   = !pe;
            u_if.PAR_TYP  = !pt;
            u_if.STOP2    = !s2;
            u_if.Prescale = (p == 8) ? PW'(16) : PW'(8);
        end
        for (int i = 0; i < int'(W); i++) begin
            u_if.RX_IN = d[i];
            wait_cycles(p);
        end
        if (pe) begin
            u_if.RX_IN = pbit;
            wait_cycles(p);
        end
        u_if.RX_IN = s0;
        wait_cycles(p);
        if (s2) begin
            u_if.RX_IN = s1;
            wait_cycles(p);
        end
        u_if.RX_IN = 1'b1;
    endtask

    always @(posedge clk) begin
        cyc   = cyc + 1;
        rst_s = rst;
        rd_s  = u_if.RD_EN;
    end

    // Model update and per-cycle comparison.
    always @(negedge clk) begin
        ev_t          cur;
        logic         e_dv, e_ov;
        logic [W-1:0] e_pd;
`ifdef UART_RX_FIFO_EN
        bit           pop;
`endif
        cur = '0;
        if (rst_s) begin
            m_pdata = '0;
            m_fifo.delete();
            m_ovr = 1'b0;
            ev_q.delete();
            live = 1'b1;
        end else if (live) begin
            if (ev_q.exists(cyc)) begin
                cur = ev_q[cyc];
                ev_q.delete(cyc);
            end
`ifdef UART_RX_FIFO_EN
            pop = rd_s && (m_fifo.size() > 0);
            if (pop) void'(m_fifo.pop_front());
            if (cur.v) begin
                if (m_fifo.size() < 4) m_fifo.push_back(cur.d);
                else m_ovr = 1'b1;
            end
`else
            if (cur.v) m_pdata = cur.d;
`endif
        end
        if (live) begin
`ifdef UART_RX_FIFO_EN
            e_dv = (m_fifo.size() > 0);
            e_pd = (m_fifo.size() > 0) ? m_fifo[0] : '0;
            e_ov = m_ovr;
`else
            e_dv = cur.v;
            e_pd = m_pdata;
            e_ov = 1'b0;
`endif
            check("P_DATA", 32'(u_if.P_DATA), 32'(e_pd));
            check("Data_valid", 32'(u_if.Data_valid), 32'(e_dv));
            check("Parity_Error", 32'(u_if.Parity_Error), 32'(cur.pe));
            check("Stop_Error", 32'(u_if.Stop_Error), 32'(cur.se));
            check("Break_Det", 32'(u_if.Break_Det), 32'(cur.bk));
            check("Overrun", 32'(u_if.Overrun), 32'(e_ov));
            if (u_if.Data_valid === 1'b1 && dv_prev !== 1'b1) begin
                n_dv_rise++;
                last_dv_cyc  = cyc;
                last_dv_data = u_if.P_DATA;
            end
            dv_prev = u_if.Data_valid;
            if (u_if.Parity_Error === 1'b1) begin n_perr++; last_perr_cyc = cyc; end
            if (u_if.Stop_Error === 1'b1) begin n_serr++; last_serr_cyc = cyc; end
            if (u_if.Break_Det === 1'b1) begin n_brk++; last_brk_cyc = cyc; end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int c0;
        int dv0;
        rst           = 1'b1;
        u_if.RX_IN    = 1'b1;
        u_if.PAR_EN   = 1'b0;
        u_if.PAR_TYP  = 1'b0;
        u_if.STOP2    = 1'b0;
        u_if.Prescale = PW'(8);
        u_if.RD_EN    = 1'b1;
        wait_cycles(3);
        check("reset_p_data", 32'(u_if.P_DATA), 32'h0);
        check("reset_valid", 32'(u_if.Data_valid), 32'h0);
        check("reset_overrun", 32'(u_if.Overrun), 32'h0);
        rst = 1'b0;
        wait_cycles(4);

        // 0xA5, even parity bit 0, Prescale 8: good frame.
        send_frame(8'hA5, 1, 0, 0, 8, 0, 1, 1, 0, c0);
        wait_cycles(8);
        check("a5_valid_cycle", 32'(last_dv_cyc), 32'(c0 + 86));
        check("a5_data", 32'(last_dv_data), 32'hA5);

        // Same frame, odd parity selected: parity error, no valid.
        dv0 = n_dv_rise;
        send_frame(8'hA5, 1, 1, 0, 8, 0, 1, 1, 0, c0);
        wait_cycles(8);
        check("a5_odd_perr_cycle", 32'(last_perr_cyc), 32'(c0 + 86));
        check("a5_odd_no_valid", 32'(n_dv_rise), 32'(dv0));
`ifndef UART_RX_FIFO_EN
        check("a5_odd_p_data_kept", 32'(u_if.P_DATA), 32'hA5);
`endif

        // Prescale 16, two stop bits, second stop low.
        send_frame(8'h3C, 0, 0, 1, 16, 0, 1, 0, 0, c0);
        wait_cycles(48);
        check("3c_serr_cycle", 32'(last_serr_cyc), 32'(c0 + 170));
        check("3c_no_valid", 32'(n_dv_rise), 32'(dv0));

        // Three-cycle glitch, then 0x55.
        u_if.STOP2    = 1'b0;
        u_if.Prescale = PW'(8);
        u_if.RX_IN    = 1'b0;
        wait_cycles(3);
        u_if.RX_IN = 1'b1;
        wait_cycles(16);
        check("glitch_no_valid", 32'(n_dv_rise), 32'(dv0));
        send_frame(8'h55, 0, 0, 0, 8, 0, 1, 1, 0, c0);
        wait_cycles(8);
        check("55_valid_cycle", 32'(last_dv_cyc), 32'(c0 + 78));
        check("55_data", 32'(last_dv_data), 32'h55);

        // Break: line low for two frame times (160 cycles at Prescale 8).
        u_if.PAR_EN = 1'b0;
        u_if.RX_IN  = 1'b0;
        c0 = cyc;
        ev_q[c0 + 78] = '{v: 1'b0, pe: 1'b0, se: 1'b0, bk: 1'b1, d: '0};
        wait_cycles(160);
        u_if.RX_IN = 1'b1;
        wait_cycles(24);
        check("break_cycle", 32'(last_brk_cyc), 32'(c0 + 78));
        check("break_count", 32'(n_brk), 32'd1);
        check("break_no_perr", 32'(n_perr), 32'd1);
        check("break_no_serr", 32'(n_serr), 32'd1);
        send_frame(8'h81, 1, 1, 0, 32, 1, 1, 1, 0, c0);
        wait_cycles(8);
        check("81_valid_cycle", 32'(last_dv_cyc), 32'(c0 + 338));
        check("81_data", 32'(last_dv_data), 32'h81);

        // Config inputs change mid-frame: frame still decoded with start values.
        send_frame(8'h3C, 1, 0, 0, 8, 0, 1, 1, 1, c0);
        wait_cycles(16);
        check("mangle_valid_cycle", 32'(last_dv_cyc), 32'(c0 + 86));
        check("mangle_data", 32'(last_dv_data), 32'h3C);

        // Back-to-back frames with no idle gap.
        dv0 = n_dv_rise;
        send_frame(8'h12, 0, 0, 0, 16, 0, 1, 1, 0, c0);
        send_frame(8'h34, 0, 0, 0, 16, 0, 1, 1, 0, c0);
        wait_cycles(16);
        check("b2b_count", 32'(n_dv_rise), 32'(dv0 + 2));
        check("b2b_data", 32'(last_dv_data), 32'h34);

        // Reset mid-frame clears outputs; next frame decodes normally.
        u_if.Prescale = PW'(8);
        u_if.RX_IN    = 1'b0;
        wait_cycles(30);
        rst = 1'b1;
        wait_cycles(1);
        check("rst_mid_p_data", 32'(u_if.P_DATA), 32'h0);
        check("rst_mid_valid", 32'(u_if.Data_valid), 32'h0);
        rst        = 1'b0;
        u_if.RX_IN = 1'b1;
        wait_cycles(16);
        send_frame(8'h5A, 0, 0, 0, 8, 0, 1, 1, 0, c0);
        wait_cycles(8);
        check("5a_data", 32'(last_dv_data), 32'h5A);

`ifdef UART_RX_FIFO_EN
        // Five frames with no pops: fifth dropped, Overrun sticks.
        u_if.RD_EN = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(W'(i), 0, 0, 0, 8, 0, 1, 1, 0, c0);
        end
        wait_cycles(8);
        check("fifo_overrun", 32'(u_if.Overrun), 32'h1);
        check("fifo_nonempty", 32'(u_if.Data_valid), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            check("fifo_pop_data", 32'(u_if.P_DATA), 32'(i));
            u_if.RD_EN = 1'b1;
            wait_cycles(1);
            u_if.RD_EN = 1'b0;
        end
        check("fifo_empty", 32'(u_if.Data_valid), 32'h0);
        u_if.RX_IN = 1'b0;
        wait_cycles(20);
        rst = 1'b1;
        wait_cycles(1);
        check("fifo_rst_overrun", 32'(u_if.Overrun), 32'h0);
        rst        = 1'b0;
        u_if.RX_IN = 1'b1;
        u_if.RD_EN = 1'b1;
        wait_cycles(16);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_gen2.md
UART_RX_GEN2 -- requirements
Module: uart_rx_gen2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter PRESCALE_W, default 6, giving the width of the Prescale input.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single receive clock.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous to CLK and active-high.
REQ-005 The block SHALL have port RX_IN, input, 1 bit: serial line, idle high.
REQ-006 The block SHALL have port PAR_EN, input, 1 bit: parity bit present.
REQ-007 The block SHALL have port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd.
REQ-008 The block SHALL have port STOP2, input, 1 bit: 1 selects two stop bits.
REQ-009 The block SHALL have port Prescale, input, PRESCALE_W bits: oversampling ratio; legal values 8, 16, 32.
REQ-010 The block SHALL have port RD_EN, input, 1 bit: FIFO pop request.
REQ-011 The block SHALL have port P_DATA, output, DATA_WIDTH bits: received word.
REQ-012 The block SHALL have port Data_valid, output, 1 bit: P_DATA is valid.
REQ-013 The block SHALL have port Parity_Error, output, 1 bit: one-cycle pulse.
REQ-014 The block SHALL have port Stop_Error, output, 1 bit: one-cycle pulse.
REQ-015 The block SHALL have port Break_Det, output, 1 bit: one-cycle pulse.
REQ-016 The block SHALL have port Overrun, output, 1 bit: sticky; cleared only by RST.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-018 In IDLE, RX_IN=0 SHALL move the FSM to START and latch PAR_EN, PAR_TYP, STOP2 and Prescale for the whole frame; changes to these inputs mid-frame SHALL have no effect.
REQ-019 The edge counter SHALL count 0..Prescale-1 per bit and wrap to 0; the bit counter SHALL advance on each wrap.
REQ-020 Each bit value SHALL be the majority of RX_IN sampled at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1.
REQ-021 A start-bit majority of 1 SHALL be treated as a glitch: return to IDLE, no outputs asserted.
REQ-022 Data bits SHALL be received LSB first into a DATA_WIDTH shift register.
REQ-023 PARITY SHALL be skipped when the latched PAR_EN=0.
REQ-024 Parity_Error SHALL be asserted when the received parity bit differs from the XOR of the data bits (even) or its inverse (odd).
REQ-025 STOP SHALL check one or two stop bits per the latched STOP2; Stop_Error SHALL be asserted if any stop-bit majority is 0.
REQ-026 Frame results SHALL appear in the cycle after the majority decision on the final stop bit, with the FSM back in IDLE in that same cycle, so back-to-back frames are received with no gap.
REQ-027 Data_valid SHALL be asserted only when neither error is present; erroneous frames SHALL NOT update P_DATA.
REQ-028 A break (all data bits 0, parity bit 0 if enabled, first stop bit 0) SHALL pulse Break_Det only, suppress Stop_Error and Parity_Error, and move to BRK_WAIT.
REQ-029 The FSM SHALL leave BRK_WAIT for IDLE only after RX_IN has been 1 for one full bit time.

Reset
REQ-030 RST=1 at any CLK edge, including mid-frame, SHALL force IDLE, clear both counters, and set P_DATA=0, Data_valid=0, Parity_Error=0, Stop_Error=0, Break_Det=0 and Overrun=0.
REQ-031 RST=1 SHALL also empty the FIFO; the partial frame SHALL be discarded.

Configuration
REQ-032 Macro UART_RX_FIFO_EN SHALL control the receive FIFO.
REQ-033 With UART_RX_FIFO_EN defined:
- valid words are written into a 4-entry FIFO.
- P_DATA shows the FIFO head; Data_valid = FIFO not empty (level signal).
- RD_EN with Data_valid pops one entry; RD_EN when empty is ignored.
- A frame completing while the FIFO is full is dropped and sets Overrun; a simultaneous pop and push at full is accepted without overrun.
REQ-034 Without UART_RX_FIFO_EN:
- Data_valid is a one-cycle pulse and P_DATA holds the last valid word.
- RD_EN is ignored and Overrun is tied 0.

Verification
REQ-035 Prescale=8, PAR_EN=1, PAR_TYP=0, byte 0xA5 with parity bit 0 and one stop bit -> P_DATA=0xA5, Data_valid asserted, no errors.
REQ-036 Same frame with PAR_TYP=1 -> Parity_Error pulse for 1 cycle, Data_valid=0, P_DATA unchanged.
REQ-037 Prescale=16, STOP2=1, 0x3C with second stop bit 0 -> Stop_Error pulse, Data_valid=0.
REQ-038 RX_IN low for 3 oversample cycles, then high -> no outputs, FSM back in IDLE; a later 0x55 frame is received correctly.
REQ-039 RX_IN held low for 2 frame times, then high -> one Break_Det pulse; the next frame 0x81 is received correctly.
REQ-040 With FIFO_EN, 5 frames 0x01..0x05 with RD_EN=0 -> Overrun=1; popping returns 0x01..0x04; RST mid-frame clears all outputs next cycle.
